align_job_ctrl: RTL and testbench

Job sequencer that drives one DP array and its traceback unit through a complete alignment. It loads the query S into the PE array and streams the reference T under busy back-pressure. It then acknowledges the score phase, waits for traceback, and buffers the traceback alignment beats in a small FIFO for the host. It sits between the host/sequence buffer and the DP+traceback top level. It is the only source of `s_update`, `new_seq`, `valid`, `ack` and `PE_end`.

---
 rtl/align_job_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_align_job_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_job_ctrl.sv
// align_job_ctrl: sequences one alignment job through the DP array and the
// traceback unit, then buffers the traceback beats for the host.
//
// Ports
//   clk, reset_i                      clock, async active-high reset
//   job_start, len_s, len_t           job request (lengths are minus 1)
//   job_idle, job_done, overflow      job status
//   seq_rd, seq_sel, seq_addr,        sequence buffer read port
//   seq_data                          (read data returns 1 cycle after seq_rd)
//   S, s_update, PE_end               query load into the PE array
//   T, valid, busy                    reference stream (busy = back-pressure)
//   new_seq, ack                      DP control strobes
//   tb_valid, done, alignment_out,
//   alignment_valid                   traceback side
//   res_data, res_valid, res_ready    result FIFO head toward the host
//
// state       | meaning
// ST_IDLE     | waiting for job_start
// ST_LOAD_S   | reading S buffer, loading PEs
// ST_NEW      | one-cycle new_seq pulse
// ST_STREAM_T | streaming T under busy back-pressure
// ST_ACK      | waiting for busy low, then ack
// ST_WAIT_TB  | waiting for traceback to start
// ST_DRAIN    | collecting alignment beats into the FIFO
// ST_FIN      | waiting for the host to empty the FIFO
module align_job_ctrl #(
   parameter int BP_W       = 3,
   parameter int LOG_N      = 6,
   parameter int LEN_W      = 12,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             job_start,
   input  logic [LOG_N-1:0] len_s,
   input  logic [LEN_W-1:0] len_t,
   output logic             job_idle,
   output logic             job_done,
   output logic             overflow,
   output logic             seq_rd,
   output logic             seq_sel,
   output logic [LEN_W-1:0] seq_addr,
   input  logic [BP_W-1:0]  seq_data,
   output logic [BP_W-1:0]  S,
   output logic             s_update,
   output logic [BP_W-1:0]  T,
   output logic             valid,
   output logic             new_seq,
   output logic [LOG_N-1:0] PE_end,
   output logic             ack,
   input  logic             busy,
   input  logic             tb_valid,
   input  logic             done,
   input  logic [BP_W-1:0]  alignment_out,
   input  logic             alignment_valid,
   output logic [BP_W-1:0]  res_data,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD_S, ST_NEW, ST_STREAM_T, ST_ACK, ST_WAIT_TB, ST_DRAIN, ST_FIN
   } state_t;

   state_t state, state_nxt;

   logic [LOG_N-1:0] len_s_q;
   logic [LEN_W-1:0] len_t_q;
   logic [LEN_W-1:0] rd_addr;
   logic [LEN_W-1:0] rd_last;
   logic             rd_active;
   logic             rd_pend;
   logic [LOG_N-1:0] s_cnt;
   logic [LEN_W-1:0] t_cnt;
   logic             s_upd_q;
   logic [BP_W-1:0]  s_q;
   logic             t_valid_q;
   logic [BP_W-1:0]  t_q;
   logic             skid_valid;
   logic [BP_W-1:0]  skid_data;
   logic [BP_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   fifo_cnt;
   logic             ovf_q;

   logic             xfer, out_free, credit, push, pop, push_ok;
   logic [1:0]       t_occ;

   assign job_idle  = (state == ST_IDLE);
   assign seq_sel   = (state == ST_STREAM_T);
   assign seq_addr  = rd_addr;
   assign S         = s_q;
   assign s_update  = s_upd_q;
   assign T         = t_q;
   assign valid     = t_valid_q;
   assign PE_end    = len_s_q;
   assign overflow  = ovf_q;
   assign res_valid = (fifo_cnt != '0);
   assign res_data  = fifo_mem[rd_ptr];

   assign xfer     = t_valid_q & ~busy;
   assign out_free = ~t_valid_q | ~busy;
   assign rd_last  = (state == ST_LOAD_S) ? LEN_W'(len_s_q) : len_t_q;

   // Beats held or in flight after this edge must fit output reg + skid,
   // counting the read issued now, assuming no transfer next cycle.
   assign t_occ  = {1'b0, t_valid_q} + {1'b0, skid_valid} + {1'b0, rd_pend};
   assign credit = (t_occ <= ({1'b0, xfer} + 2'd1));

   assign pop     = res_valid & res_ready;
   assign push_ok = push & ((fifo_cnt != FIFO_FULL) | pop);

   always_comb begin
      state_nxt = state;
      seq_rd    = 1'b0;
      new_seq   = 1'b0;
      ack       = 1'b0;
      job_done  = 1'b0;
      push      = 1'b0;
      case (state)
         ST_IDLE:     if (job_start) state_nxt = ST_LOAD_S;
         ST_LOAD_S: begin
            seq_rd = rd_active;
            if (s_upd_q && s_cnt == len_s_q) state_nxt = ST_NEW;
         end
         ST_NEW: begin
            new_seq   = 1'b1;
            state_nxt = ST_STREAM_T;
         end
         ST_STREAM_T: begin
            seq_rd = rd_active & credit;
            if (xfer && t_cnt == len_t_q) state_nxt = ST_ACK;
         end
         ST_ACK: begin
            if (!busy) begin
               ack       = 1'b1;
               state_nxt = ST_WAIT_TB;
            end
         end
         ST_WAIT_TB:  if (tb_valid) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            push = alignment_valid;
            if (done) state_nxt = ST_FIN;
         end
         ST_FIN: begin
            if (fifo_cnt == '0) begin
               job_done  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default:     state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state     <= ST_IDLE;
         len_s_q   <= '0;
         len_t_q   <= '0;
         rd_addr   <= '0;
         rd_active <= 1'b0;
         rd_pend   <= 1'b0;
         s_cnt     <= '0;
         t_cnt     <= '0;
         s_upd_q   <= 1'b0;
         s_q       <= '0;
      end else begin
         state   <= state_nxt;
         rd_pend <= seq_rd;
         s_upd_q <= 1'b0;
         if (state == ST_IDLE && job_start) begin
            len_s_q   <= len_s;
            len_t_q   <= len_t;
            rd_addr   <= '0;
            rd_active <= 1'b1;
            s_cnt     <= '0;
            t_cnt     <= '0;
         end
         if (state == ST_NEW) begin
            rd_addr   <= '0;
            rd_active <= 1'b1;
         end
         // Address stops on the last index instead of wrapping past it.
         if (seq_rd) begin
            if (rd_addr == rd_last) rd_active <= 1'b0;
            else                    rd_addr   <= rd_addr + 1'b1;
         end
         if (state == ST_LOAD_S && rd_pend) begin
            s_q     <= seq_data;
            s_upd_q <= 1'b1;
         end
         if (s_upd_q) s_cnt <= s_cnt + 1'b1;
         if (xfer)    t_cnt <= t_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         t_valid_q  <= 1'b0;
         t_q        <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (state != ST_STREAM_T) begin
         t_valid_q  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         if (skid_valid) begin
            t_q        <= skid_data;
            t_valid_q  <= 1'b1;
            skid_valid <= rd_pend;
            skid_data  <= seq_data;
         end else begin
            t_valid_q <= rd_pend;
            if (rd_pend) t_q <= seq_data;
         end
      end else if (rd_pend) begin
         skid_valid <= 1'b1;
         skid_data  <= seq_data;
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push_ok) begin
            fifo_mem[wr_ptr] <= alignment_out;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
         if (state == ST_IDLE && job_start) ovf_q <= 1'b0;
         else if (push && !push_ok)         ovf_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_align_job_ctrl.sv
// Self-checking bench for align_job_ctrl: sequence-buffer model, reference
// FIFO model, event logging, and directed jobs with randomized data/handshakes.
module tb_align_job_ctrl;
   localparam int BP_W  = 3;
   localparam int LOG_N = 6;
   localparam int LEN_W = 12;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset_i;
   logic job_start;
   logic [LOG_N-1:0] len_s;
   logic [LEN_W-1:0] len_t;
   logic job_idle, job_done, overflow, seq_rd, seq_sel;
   logic [LEN_W-1:0] seq_addr;
   logic [BP_W-1:0] seq_data;
   logic [BP_W-1:0] S, T, res_data, alignment_out;
   logic s_update, valid, new_seq, ack, res_valid;
   logic [LOG_N-1:0] PE_end;
   logic busy, tb_valid, done, alignment_valid, res_ready;

   align_job_ctrl #(.BP_W(BP_W), .LOG_N(LOG_N), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_i(reset_i), .job_start(job_start), .len_s(len_s), .len_t(len_t),
      .job_idle(job_idle), .job_done(job_done), .overflow(overflow),
      .seq_rd(seq_rd), .seq_sel(seq_sel), .seq_addr(seq_addr), .seq_data(seq_data),
      .S(S), .s_update(s_update), .T(T), .valid(valid), .new_seq(new_seq),
      .PE_end(PE_end), .ack(ack), .busy(busy), .tb_valid(tb_valid), .done(done),
      .alignment_out(alignment_out), .alignment_valid(alignment_valid),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sequence buffers: data for a read appears the cycle after seq_rd.
   logic [BP_W-1:0] s_buf [64];
   logic [BP_W-1:0] t_buf [4096];
   logic rq = 1'b0;
   logic rq_sel = 1'b0;
   logic [LEN_W-1:0] rq_addr = '0;
   always @(negedge clk) begin
      rq      <= seq_rd;
      rq_sel  <= seq_sel;
      rq_addr <= seq_addr;
   end
   always @(posedge clk) begin
      #1;
      if (rq) seq_data = rq_sel ? t_buf[rq_addr] : s_buf[rq_addr[LOG_N-1:0]];
      else    seq_data = BP_W'($urandom);
   end

   // Event log and reference FIFO, sampled mid-cycle.
   bit mon_en = 1'b0;
   bit drain_flag = 1'b0;
   bit exp_ovf = 1'b0;
   logic [BP_W-1:0] s_seen [$];
   logic [BP_W-1:0] t_seen [$];
   logic [BP_W-1:0] mq [$];
   int n_new, n_ack, n_done;
   int t_rd, t_su, t_new, t_ack, t_done, t_last, t_pop;
   logic pv, pb;
   logic [BP_W-1:0] pT;

   always @(negedge clk) begin
      if (mon_en) begin
         if (seq_rd && t_rd < 0) t_rd = cyc;
         if (s_update) begin
            s_seen.push_back(S);
            if (t_su < 0) t_su = cyc;
         end
         if (new_seq)  begin n_new++;  t_new = cyc;  end
         if (ack)      begin n_ack++;  t_ack = cyc;  end
         if (job_done) begin n_done++; t_done = cyc; end
         if (pv && pb) begin
            chk("valid_hold", valid, 1);
            chk("t_hold", T, pT);
         end
         if (valid && !busy) begin
            t_seen.push_back(T);
            t_last = cyc;
         end
         pv = valid; pb = busy; pT = T;
         chk("res_valid", res_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("res_data", res_data, mq[0]);
            if (res_ready) begin
               void'(mq.pop_front());
               t_pop = cyc;
            end
         end
         if (drain_flag && alignment_valid) begin
            if (mq.size() < DEPTH) mq.push_back(alignment_out);
            else exp_ovf = 1'b1;
         end
      end
   end

   int pat [6] = '{1, 0, 0, 1, 1, 0};

   function automatic logic pick_ready(input int m);
      if (m == 1) return 1'b1;
      if (m == 2) return 1'($urandom_range(0, 1));
      return 1'b0;
   endfunction

   // bmode: 0 no busy, 1 fixed pattern, 2 random. rmode: 0 hold off, 1 always, 2 random.
   task automatic run_job(input int ls, input int lt, input int bmode, input int nbeats,
                          input int rmode, input bit ign_start, input bit done_same);
      int start, budget, bidx, bad, fin_i;
      bit got;
      for (int i = 0; i < 64; i++) s_buf[i] = BP_W'($urandom);
      for (int i = 0; i <= lt; i++) t_buf[i] = BP_W'($urandom);
      s_seen.delete(); t_seen.delete(); mq.delete();
      n_new = 0; n_ack = 0; n_done = 0;
      t_rd = -1; t_su = -1; t_new = -1; t_ack = -1; t_done = -1; t_last = -1; t_pop = -1;
      pv = 1'b0; pb = 1'b0; pT = '0; exp_ovf = 1'b0;
      mon_en = 1'b1;

      len_s = LOG_N'(ls); len_t = LEN_W'(lt); job_start = 1'b1;
      start = cyc;
      step();
      job_start = 1'b0;
      len_s = LOG_N'($urandom); len_t = LEN_W'($urandom);
      chk("ovf_clr_at_start", overflow, 0);
      chk("idle_low", job_idle, 0);

      budget = 8 * (ls + lt) + 100; bidx = 0; got = 1'b0;
      while (!got && budget > 0) begin
         busy = (bmode == 0) ? 1'b0 : (bmode == 1) ? 1'(pat[bidx % 6]) : 1'($urandom_range(0, 1));
         job_start = ign_start && (bidx == ls + 10);
         if (job_start) begin len_s = '0; len_t = 1; end
         bidx++;
         #1;
         if (ack) got = 1'b1;
         step();
         budget--;
      end
      chk("ack_seen", got, 1);

      busy = 1'b0; job_start = 1'b0;
      tb_valid = 1'b1; alignment_valid = 1'b1; alignment_out = BP_W'($urandom);
      res_ready = pick_ready(rmode);
      step();
      tb_valid = 1'b0; drain_flag = 1'b1;
      bidx = 0;
      while (bidx < nbeats) begin
         res_ready = pick_ready(rmode);
         if (rmode == 2 && $urandom_range(0, 2) == 0) alignment_valid = 1'b0;
         else begin
            alignment_valid = 1'b1;
            alignment_out = BP_W'($urandom);
            bidx++;
         end
         done = done_same && (bidx == nbeats) && alignment_valid;
         step();
      end
      if (!done_same) begin
         alignment_valid = 1'b0; done = 1'b1; res_ready = pick_ready(rmode);
         step();
      end
      drain_flag = 1'b0; done = 1'b0;
      alignment_valid = 1'b1; alignment_out = BP_W'($urandom);

      budget = 200; got = 1'b0; fin_i = 0;
      while (!got && budget > 0) begin
         res_ready = (rmode == 0 && fin_i < 3) ? 1'b0 : (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         fin_i++;
         #1;
         if (job_done) got = 1'b1;
         step();
         alignment_valid = 1'b0;
         budget--;
      end
      chk("job_done_seen", got, 1);
      res_ready = 1'b0; alignment_valid = 1'b0;

      bad = 0;
      for (int i = 0; i <= ls; i++) if (i >= s_seen.size() || s_seen[i] !== s_buf[i]) bad++;
      chk("s_update_count", s_seen.size(), ls + 1);
      chk("s_data_bad", bad, 0);
      bad = 0;
      for (int i = 0; i <= lt; i++) if (i >= t_seen.size() || t_seen[i] !== t_buf[i]) bad++;
      chk("t_xfer_count", t_seen.size(), lt + 1);
      chk("t_data_bad", bad, 0);
      chk("new_seq_count", n_new, 1);
      chk("ack_count", n_ack, 1);
      chk("job_done_count", n_done, 1);
      chk("first_seq_rd", t_rd, start + 1);
      chk("first_s_update", t_su, start + 3);
      chk("new_seq_time", t_new, start + ls + 4);
      if (bmode == 0) chk("ack_after_last_t", t_ack, t_last + 1);
      chk("done_after_pop", t_done > t_pop, 1);
      chk("overflow_end", overflow, exp_ovf);
      chk("pe_end", PE_end, ls);
      chk("idle_end", job_idle, 1);
      chk("fifo_empty_end", res_valid, 0);
   endtask

   initial begin
      int budget;
      reset_i = 1'b1; job_start = 1'b0; len_s = '0; len_t = '0;
      busy = 1'b0; tb_valid = 1'b0; done = 1'b0; alignment_out = '0;
      alignment_valid = 1'b0; res_ready = 1'b0;
      step(); step();
      chk("rst_idle", job_idle, 1);
      chk("rst_outs", {job_done, overflow, seq_rd, s_update, valid, new_seq, ack, res_valid}, 0);
      chk("rst_data", {S, T, res_data, seq_addr, PE_end}, 0);
      reset_i = 1'b0;
      step();
      chk("idle_after_rst", job_idle, 1);

      run_job(3, 7, 0, 5, 1, 1'b0, 1'b1);
      run_job(5, 15, 1, 6, 2, 1'b1, 1'b1);
      run_job(2, 9, 2, 10, 0, 1'b0, 1'b0);
      chk("overflow_sticky", overflow, 1);
      run_job(1, 4, 2, 3, 2, 1'b0, 1'b1);
      chk("overflow_cleared", overflow, 0);

      // Reset while beats sit in the FIFO during DRAIN.
      mon_en = 1'b0;
      for (int i = 0; i < 64; i++) s_buf[i] = BP_W'($urandom | 1);
      for (int i = 0; i < 8; i++) t_buf[i] = BP_W'($urandom | 1);
      len_s = 2; len_t = 3; job_start = 1'b1;
      step();
      job_start = 1'b0;
      budget = 100;
      while (!ack && budget > 0) begin step(); budget--; end
      chk("rst_job_ack", ack, 1);
      step();
      tb_valid = 1'b1;
      step();
      tb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alignment_valid = 1'b1; alignment_out = BP_W'($urandom | 1);
         step();
      end
      chk("pre_rst_res_valid", res_valid, 1);
      #2;
      reset_i = 1'b1;
      #1;
      chk("mid_rst_idle", job_idle, 1);
      chk("mid_rst_res_valid", res_valid, 0);
      chk("mid_rst_outs", {job_done, overflow, seq_rd, s_update, valid, new_seq, ack}, 0);
      chk("mid_rst_data", {S, T, res_data, seq_addr, PE_end}, 0);
      alignment_valid = 1'b0;
      step();
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("post_rst_idle", job_idle, 1);
         chk("post_rst_quiet", {seq_rd, s_update, valid, new_seq, ack, job_done, res_valid}, 0);
      end

      run_job(63, 4095, 0, 4, 1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
